// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle IDLE/DECODE/EXEC/WB control for an ALU and register file.
// Define ALU_SEQ_PERF_EN to build the exec_count/skip_count performance counters.
module alu_sequencer #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [1:0]  alu_cond,
  output logic [3:0]  alu_op_c,
  output logic [6:0]  alu_ld_sh,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_flag,
  output logic [2:0]  rf_rd_addr1,
  output logic [2:0]  rf_rd_addr2,
  output logic        rf_we,
  output logic [2:0]  rf_wr_addr,
  output logic [15:0] rf_wr_data,
  output logic [3:0]  flags,
  output logic        busy,
  output logic [15:0] exec_count,
  output logic [15:0] skip_count
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_LAST_WR = 4'b1010;

  state_t     state;
  logic [2:0] rd;
  logic [2:0] cnt;
  logic       cond_met;
  logic       cond_ok;
  logic       exec_done;
  logic       op_writes;
  logic       op_flags;
  logic       op_counted;

  // Condition check against the architectural flags {N,Z,C,V}
  always_comb begin
    cond_ok = 1'b0;
    unique case (alu_cond)
      2'b00: cond_ok = 1'b1;
      2'b01: cond_ok = flags[2];
      2'b10: cond_ok = ~flags[2];
      2'b11: cond_ok = flags[3] ^ flags[0];
    endcase
  end

  assign exec_done  = (state == EXEC) && (cnt == 3'd0);
  assign op_writes  = (alu_op_c <= OP_LAST_WR);
  assign op_flags   = (alu_op_c <= OP_MUL) || (alu_op_c == OP_CMP);
  assign op_counted = (alu_op_c <= OP_CMP);

  // Sequencer FSM; results and flags commit on entry to WB
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      alu_cond    <= '0;
      alu_op_c    <= '0;
      alu_ld_sh   <= '0;
      rf_rd_addr1 <= '0;
      rf_rd_addr2 <= '0;
      rd          <= '0;
      cnt         <= '0;
      cond_met    <= 1'b0;
      rf_we       <= 1'b0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      flags       <= '0;
    end else begin
      rf_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            alu_cond    <= instr[15:14];
            alu_op_c    <= instr[13:10];
            alu_ld_sh   <= instr[6:0];
            rf_rd_addr1 <= instr[6:4];
            rf_rd_addr2 <= instr[3:1];
            rd          <= instr[9:7];
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= DECODE;
          end
        end
        DECODE: begin
          cond_met <= cond_ok;
          if (alu_op_c == OP_MUL) begin
            cnt <= 3'(MUL_LAT - 1);
          end else begin
            cnt <= 3'd0;
          end
          state <= EXEC;
        end
        EXEC: begin
          if (cnt == 3'd0) begin
            if (cond_met && op_writes) begin
              rf_we      <= 1'b1;
              rf_wr_addr <= rd;
              rf_wr_data <= alu_result;
            end
            if (cond_met && op_flags) begin
              flags <= alu_flag;
            end
            state <= WB;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WB: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Performance counters, bumped as each instruction retires into WB
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_count <= '0;
      skip_count <= '0;
    end else if (exec_done) begin
      if (cond_met && op_counted) begin
        exec_count <= exec_count + 16'd1;
      end
      if (!cond_met) begin
        skip_count <= skip_count + 16'd1;
      end
    end
  end
`else
  assign exec_count = 16'd0;
  assign skip_count = 16'd0;
`endif

endmodule
